// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD display converter:
// display code constants, FSM state type and a digit-count helper.
package bcd_pkg;

   // Display codes understood by the downstream 7-segment decoders
   localparam logic [3:0] BCD_TRACO   = 4'hA;   // dash / minus sign
   localparam logic [3:0] BCD_F       = 4'hB;   // letter "F"
   localparam logic [3:0] BCD_APAGADO = 4'hF;   // blank position

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      FMT  = 2'd2
   } bcd_state_t;

   // Minimum display positions (magnitude digits plus sign) for a signed
   // input of the given width: decimal digits of 2^(width-1), plus one.
   function automatic int bcd_min_digits(input int width);
      longint unsigned p;
      int              d;
      p = 64'd1 << (width - 1);
      d = 0;
      for (int k = 0; k < 20; k++) begin
         if (p != 64'd0) begin
            d = d + 1;
            p = p / 64'd10;
         end
      end
      return d + 1;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
   input  logic [3:0] nib,
   output logic [3:0] adj
);

   // Conditional +3 correction
   always_comb begin
      if (nib >= 4'd5) begin
         adj = nib + 4'd3;
      end else begin
         adj = nib;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: signed ALU result -> per-digit display
// codes (0-9 digit, A dash, B "F", F blank). Overflow shows as "OF".
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros and moves
// the minus sign next to the most significant displayed digit.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   input  logic                  ovf_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   digits_out
);

   localparam int ACC_W = 4 * (DIGITS - 1);
   localparam int CNT_W = $clog2(WIDTH + 1);

   // Reject configurations whose magnitude digits cannot hold 2^(WIDTH-1)
   if (DIGITS < bcd_min_digits(WIDTH)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
   end

   bcd_state_t          state_r;
   bcd_state_t          next_s;
   logic [ACC_W-1:0]    acc_r;
   logic [ACC_W-1:0]    adj_s;
   logic [WIDTH-1:0]    mag_r;
   logic [WIDTH-1:0]    abs_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                neg_r;
   logic                ovf_r;
   logic                busy_r;
   logic                done_r;
   logic [4*DIGITS-1:0] digits_r;
   logic [4*DIGITS-1:0] fmt_s;
`ifdef LEADING_ZERO_BLANK_EN
   logic                lead_s;
`endif

   // Per-nibble +3 correction of the accumulator
   for (genvar g = 0; g < DIGITS - 1; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nib (acc_r[4*g +: 4]),
         .adj (adj_s[4*g +: 4])
      );
   end

   // Magnitude of the two's-complement input; the most negative value maps
   // to 2^(WIDTH-1), which still fits WIDTH unsigned bits
   always_comb begin
      if (value[WIDTH-1]) begin
         abs_s = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         abs_s = value;
      end
   end

   // Next-state logic
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_s = CONV;
            end else begin
               next_s = IDLE;
            end
         end
         CONV: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               next_s = FMT;
            end else begin
               next_s = CONV;
            end
         end
         FMT:     next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Display code formatting of the finished accumulator
   always_comb begin
      fmt_s = {(4*DIGITS){1'b1}};
`ifdef LEADING_ZERO_BLANK_EN
      lead_s = 1'b1;
`endif
      if (ovf_r) begin
         fmt_s[7:4] = 4'h0;
         fmt_s[3:0] = BCD_F;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
         // Scan from the left; the first nonzero digit (or nibble 0) ends
         // the blanking run and gets the sign placed just left of it
         for (int i = DIGITS - 2; i >= 0; i--) begin
            if (lead_s && (acc_r[4*i +: 4] == 4'h0) && (i != 0)) begin
               fmt_s[4*i +: 4] = BCD_APAGADO;
            end else begin
               if (lead_s && neg_r) begin
                  fmt_s[4*(i+1) +: 4] = BCD_TRACO;
               end else begin
                  fmt_s[4*(i+1) +: 4] = fmt_s[4*(i+1) +: 4];
               end
               lead_s          = 1'b0;
               fmt_s[4*i +: 4] = acc_r[4*i +: 4];
            end
         end
`else
         fmt_s[ACC_W-1:0] = acc_r;
         if (neg_r) begin
            fmt_s[4*(DIGITS-1) +: 4] = BCD_TRACO;
         end else begin
            fmt_s[4*(DIGITS-1) +: 4] = BCD_APAGADO;
         end
`endif
      end
   end

   // State register, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         acc_r    <= {ACC_W{1'b0}};
         mag_r    <= {WIDTH{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         neg_r    <= 1'b0;
         ovf_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         digits_r <= {(4*DIGITS){1'b1}};
      end else begin
         state_r <= next_s;
         done_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  mag_r  <= abs_s;
                  acc_r  <= {ACC_W{1'b0}};
                  cnt_r  <= CNT_W'(WIDTH);
                  neg_r  <= value[WIDTH-1];
                  ovf_r  <= ovf_in;
                  busy_r <= 1'b1;
               end
            end
            CONV: begin
               if (cnt_r != {CNT_W{1'b0}}) begin
                  acc_r <= {adj_s[ACC_W-2:0], mag_r[WIDTH-1]};
                  mag_r <= {mag_r[WIDTH-2:0], 1'b0};
                  cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            FMT: begin
               digits_r <= fmt_s;
               done_r   <= 1'b1;
               busy_r   <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign digits_out = digits_r;

endmodule
